// File: rtl/hft_egress_pkg.sv
// hft_egress_pkg
//   Shared types and constants for the quote egress scheduler. It holds the
//   FSM state encoding, the buffered quote-pair entry layout, and a helper
//   that extracts one word from a packed message.
package hft_egress_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int NUM_WORDS  = 9;
  localparam int MSG_W      = NUM_WORDS * REG_WIDTH;
  localparam int COOLDOWN_W = 8;
  localparam int IDX_W      = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_GAP  = 2'd1,
    SEND_BUY  = 2'd2,
    SEND_SELL = 2'd3
  } egress_state_t;

  typedef struct packed {
    logic [1:0]       stock_id;
    logic [MSG_W-1:0] buy_msg;
    logic [MSG_W-1:0] sell_msg;
  } quote_entry_t;

  // Word k of a message sits at bits [k*REG_WIDTH +: REG_WIDTH].
  function automatic logic [REG_WIDTH-1:0] msg_word(input logic [MSG_W-1:0] msg,
                                                    input logic [IDX_W-1:0] idx);
    msg_word = msg[int'(idx)*REG_WIDTH +: REG_WIDTH];
  endfunction

endpackage

// File: rtl/quote_fifo.sv
// quote_fifo
//   DEPTH-entry FIFO of quote pairs. Only the pointers, count and flags are
//   reset; the payload storage is not.
//   Ports: i_clk, i_reset_n (async, active-low), i_push, i_pop, i_data,
//          o_head (entry at the read pointer), o_count, o_full, o_empty
//          (flags registered from the next count).
module quote_fifo
  import hft_egress_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  quote_entry_t     i_data,
  output quote_entry_t     o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  quote_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_full;
  logic             r_empty;

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    w_count_next = r_count;
    if (i_push && !i_pop) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (i_pop && !i_push) begin
      w_count_next = r_count - CNT_W'(1);
    end else begin
      w_count_next = r_count;
    end
  end

  // Pointers, count and registered full/empty flags.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == CNT_W'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  // Payload storage; when full, a same-cycle push reuses the slot being popped.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/quote_egress_scheduler.sv
// quote_egress_scheduler
//   Buffers buy/sell quote pairs and streams each pair as 9 buy words then
//   9 sell words on a 32-bit valid/ready egress port, enforcing a per-stock
//   cooldown between consecutive pairs of the same stock. All stream outputs
//   are registered; i_tx_ready has no combinational path to any output.
//   Ports: i_clk, i_reset_n (async, active-low), i_quote_valid, i_stock_id,
//          i_buy_msg, i_sell_msg, i_tx_ready, o_tx_valid, o_tx_data,
//          o_tx_last, o_tx_side (0 buy / 1 sell), o_full, o_busy,
//          o_drop_count (saturating).
module quote_egress_scheduler
  import hft_egress_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int NUM_STOCKS      = 4,
  parameter int THROTTLE_CYCLES = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_quote_valid,
  input  logic [1:0]           i_stock_id,
  input  logic [MSG_W-1:0]     i_buy_msg,
  input  logic [MSG_W-1:0]     i_sell_msg,
  input  logic                 i_tx_ready,
  output logic                 o_tx_valid,
  output logic [REG_WIDTH-1:0] o_tx_data,
  output logic                 o_tx_last,
  output logic                 o_tx_side,
  output logic                 o_full,
  output logic                 o_busy,
  output logic [15:0]          o_drop_count
);

  localparam int               CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  egress_state_t          r_state;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_tx_valid;
  logic [REG_WIDTH-1:0]   r_tx_data;
  logic                   r_tx_last;
  logic                   r_tx_side;
  logic [15:0]            r_drop_count;
  logic [COOLDOWN_W-1:0]  r_cooldown [NUM_STOCKS];

  quote_entry_t           w_in_entry;
  quote_entry_t           w_head;
  logic [CNT_W-1:0]       w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_hs;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic [COOLDOWN_W-1:0]  w_head_cd;

  assign w_in_entry = {i_stock_id, i_buy_msg, i_sell_msg};
  assign w_hs       = r_tx_valid & i_tx_ready;
  assign w_pop      = w_hs & (r_state == SEND_SELL) & (r_idx == LAST_IDX);
  assign w_push     = i_quote_valid & ((w_count < CNT_W'(DEPTH)) | w_pop);
  assign w_drop     = i_quote_valid & ~w_push;
  assign w_head_cd  = r_cooldown[w_head.stock_id];

  quote_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_data    (w_in_entry),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Egress FSM with registered stream outputs; the word for the next cycle is
  // loaded on the edge where the current word is accepted.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_tx_last  <= 1'b0;
      r_tx_side  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            if (w_head_cd == '0) begin
              r_state    <= SEND_BUY;
              r_idx      <= '0;
              r_tx_valid <= 1'b1;
              r_tx_data  <= msg_word(w_head.buy_msg, IDX_W'(0));
              r_tx_last  <= 1'b0;
              r_tx_side  <= 1'b0;
            end else begin
              r_state <= WAIT_GAP;
            end
          end
        end
        WAIT_GAP: begin
          // A count of 1 reaches zero at this edge, so the first word lands
          // on the first cycle the stock is no longer cooling.
          if (w_head_cd <= COOLDOWN_W'(1)) begin
            r_state    <= SEND_BUY;
            r_idx      <= '0;
            r_tx_valid <= 1'b1;
            r_tx_data  <= msg_word(w_head.buy_msg, IDX_W'(0));
            r_tx_last  <= 1'b0;
            r_tx_side  <= 1'b0;
          end
        end
        SEND_BUY: begin
          if (w_hs) begin
            if (r_idx == LAST_IDX) begin
              r_state   <= SEND_SELL;
              r_idx     <= '0;
              r_tx_data <= msg_word(w_head.sell_msg, IDX_W'(0));
              r_tx_last <= 1'b0;
              r_tx_side <= 1'b1;
            end else begin
              r_idx     <= r_idx + IDX_W'(1);
              r_tx_data <= msg_word(w_head.buy_msg, r_idx + IDX_W'(1));
              r_tx_last <= ((r_idx + IDX_W'(1)) == LAST_IDX);
            end
          end
        end
        SEND_SELL: begin
          if (w_hs) begin
            if (r_idx == LAST_IDX) begin
              r_state    <= IDLE;
              r_idx      <= '0;
              r_tx_valid <= 1'b0;
              r_tx_data  <= '0;
              r_tx_last  <= 1'b0;
              r_tx_side  <= 1'b0;
            end else begin
              r_idx     <= r_idx + IDX_W'(1);
              r_tx_data <= msg_word(w_head.sell_msg, r_idx + IDX_W'(1));
              r_tx_last <= ((r_idx + IDX_W'(1)) == LAST_IDX);
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_idx      <= '0;
          r_tx_valid <= 1'b0;
        end
      endcase
    end
  end

  // Per-stock cooldown: a pop reloads the popped stock, overriding its decrement.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int s = 0; s < NUM_STOCKS; s++) r_cooldown[s] <= '0;
    end else begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        if (w_pop && (w_head.stock_id == 2'(s))) begin
          r_cooldown[s] <= COOLDOWN_W'(THROTTLE_CYCLES);
        end else if (r_cooldown[s] != '0) begin
          r_cooldown[s] <= r_cooldown[s] - COOLDOWN_W'(1);
        end
      end
    end
  end

  // Saturating count of rejected pairs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_drop_count <= 16'd0;
    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign o_tx_valid   = r_tx_valid;
  assign o_tx_data    = r_tx_data;
  assign o_tx_last    = r_tx_last;
  assign o_tx_side    = r_tx_side;
  assign o_full       = w_full;
  // Every non-IDLE state holds a buffered entry, so both terms are registered.
  assign o_busy       = ~w_empty | (r_state != IDLE);
  assign o_drop_count = r_drop_count;

endmodule
